// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequenced 32x32 signed multiplier.
// Optional build macro: MUL_SEQ_EARLY_OUT_EN (skip partial products whose
// operand half is zero).
package mul_seq_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  // IDLE waits for operands, P0..P3 accumulate one partial product each,
  // FIX applies the sign, DONE presents the result until it is taken.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    FIX  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Left shift applied to each partial product, indexed by P-state number:
  // al*bl at 0, ah*bl at 16, al*bh at 16, ah*bh at 32.
  localparam logic [5:0] P_SHIFT [0:3] = '{6'd0, 6'd16, 6'd16, 6'd32};

  // Unsigned magnitude of a two's complement word; the most negative value
  // maps to 0x8000_0000, which is exactly its magnitude as an unsigned number.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (~v + WORD_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul16.sv
// Combinational 16x16 unsigned multiplier shared by the sequenced unit.
module mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul_seq.sv
// Sequenced signed 32x32 multiplier: one mul16 is time-multiplexed over four
// partial products that accumulate into a 64-bit register, then the sign is
// applied and the low word plus a signed-overflow flag are presented.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; in_ready is high only in IDLE, and out_valid/out_result/
// out_overflow hold steady from DONE entry until out_ready is seen.
// Optional build macro: MUL_SEQ_EARLY_OUT_EN.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_overflow,
  output logic              busy,
  output state_t            dbg_state
);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   a_mag_q, a_mag_d;
  logic [WORD_W-1:0]   b_mag_q, b_mag_d;
  logic                neg_q, neg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;

  logic [1:0]          p_idx;
  logic [HALF_W-1:0]   mul_a;
  logic [HALF_W-1:0]   mul_b;
  logic [2*HALF_W-1:0] prod;
  logic [ACC_W-1:0]    partial;
  logic [ACC_W-1:0]    acc_fix;
  logic [3:1]          skip;

`ifdef MUL_SEQ_EARLY_OUT_EN
  logic                zh_a_q, zh_a_d;
  logic                zh_b_q, zh_b_d;

  // A zero upper half makes every partial product using it zero.
  assign skip = {zh_a_q | zh_b_q, zh_b_q, zh_a_q};
`else
  assign skip = 3'b000;
`endif

  // Select the operand halves for the partial product of the current P state.
  always_comb begin
    p_idx = 2'd0;
    case (state_q)
      P1:      p_idx = 2'd1;
      P2:      p_idx = 2'd2;
      P3:      p_idx = 2'd3;
      default: p_idx = 2'd0;
    endcase
    mul_a = p_idx[0] ? a_mag_q[WORD_W-1:HALF_W] : a_mag_q[HALF_W-1:0];
    mul_b = p_idx[1] ? b_mag_q[WORD_W-1:HALF_W] : b_mag_q[HALF_W-1:0];
  end

  mul16 u_mul16 (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Next-state, accumulate, sign-fix and result capture.
  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
`ifdef MUL_SEQ_EARLY_OUT_EN
    zh_a_d   = zh_a_q;
    zh_b_d   = zh_b_q;
`endif
    partial  = {{(ACC_W-2*HALF_W){1'b0}}, prod} << P_SHIFT[p_idx];
    acc_fix  = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_mag_d = magnitude(in_a);
          b_mag_d = magnitude(in_b);
          neg_d   = in_a[WORD_W-1] ^ in_b[WORD_W-1];
          acc_d   = '0;
`ifdef MUL_SEQ_EARLY_OUT_EN
          zh_a_d  = (a_mag_d[WORD_W-1:HALF_W] == '0);
          zh_b_d  = (b_mag_d[WORD_W-1:HALF_W] == '0);
`endif
          state_d = P0;
        end
      end
      P0: begin
        acc_d = acc_q + partial;
        if (!skip[1])      state_d = P1;
        else if (!skip[2]) state_d = P2;
        else if (!skip[3]) state_d = P3;
        else               state_d = FIX;
      end
      P1: begin
        acc_d = acc_q + partial;
        if (!skip[2])      state_d = P2;
        else if (!skip[3]) state_d = P3;
        else               state_d = FIX;
      end
      P2: begin
        acc_d = acc_q + partial;
        if (!skip[3]) state_d = P3;
        else          state_d = FIX;
      end
      P3: begin
        acc_d   = acc_q + partial;
        state_d = FIX;
      end
      FIX: begin
        // Overflow unless bits 63..31 are a pure sign extension.
        acc_d    = acc_fix;
        result_d = acc_fix[WORD_W-1:0];
        ovf_d    = !((&acc_fix[ACC_W-1:WORD_W-1]) || (~|acc_fix[ACC_W-1:WORD_W-1]));
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
`ifdef MUL_SEQ_EARLY_OUT_EN
      zh_a_q   <= 1'b0;
      zh_b_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
`ifdef MUL_SEQ_EARLY_OUT_EN
      zh_a_q   <= zh_a_d;
      zh_b_q   <= zh_b_d;
`endif
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_result   = result_q;
  assign out_overflow = ovf_q;
  assign dbg_state    = state_q;

endmodule
